mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter fronting a word register bank; fixed 3-cycle req-to-ack latency.
// Requesters hold req until ack; requests seen while busy wait for the next IDLE.
module mem_arbiter #(
  parameter logic [31:0] BASE = 32'h10000000,
  parameter int          NREG = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        Mem_rd,
  output logic        Mem_wr,
  output logic [31:0] Dir_Mem,
  output logic [31:0] Dato_Mem_in,
  input  logic [31:0] Dato_Mem_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  // 33-bit bound so a bank placed at the top of the address space cannot wrap
  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(4 * NREG);

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        win_id;
  logic        win_wr;
  logic        win_map;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        gnt_id;
  logic        last_gnt;
  logic        lat_wr;
  logic        lat_map;

  function automatic logic is_mapped(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < LIMIT) && (a[1:0] == 2'b00);
  endfunction

  // On contention the requester not granted last wins
  always_comb begin
    win_id = 1'b0;
    if (req0 && req1) begin
      win_id = ~last_gnt;
    end else if (req1) begin
      win_id = 1'b1;
    end
    win_wr    = win_id ? wr1    : wr0;
    win_addr  = win_id ? addr1  : addr0;
    win_wdata = win_id ? wdata1 : wdata0;
    win_map   = is_mapped(win_addr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b1;
    Mem_rd    = 1'b1;
    Mem_wr    = 1'b1;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req0 || req1) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (lat_map) begin
          Mem_rd = lat_wr;
          Mem_wr = ~lat_wr;
        end
        state_nxt = CAPT;
      end
      CAPT: begin
        state_nxt = RESP;
      end
      RESP: begin
        ack0      = ~gnt_id;
        ack1      = gnt_id;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bank address/data only move for mapped accesses, so they hold across unmapped ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_id      <= 1'b0;
      last_gnt    <= 1'b1;
      lat_wr      <= 1'b0;
      lat_map     <= 1'b0;
      Dir_Mem     <= 32'd0;
      Dato_Mem_in <= 32'd0;
      rdata       <= 32'd0;
      err         <= 1'b0;
    end else begin
      if (accept) begin
        gnt_id  <= win_id;
        lat_wr  <= win_wr;
        lat_map <= win_map;
        if (win_map) begin
          Dir_Mem     <= win_addr;
          Dato_Mem_in <= win_wdata;
        end
      end
      case (state)
        CAPT: begin
          rdata <= (lat_map && !lat_wr) ? Dato_Mem_out : 32'd0;
          err   <= ~lat_map;
        end
        RESP: begin
          rdata    <= 32'd0;
          err      <= 1'b0;
          last_gnt <= gnt_id;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural register bank plus an ack scoreboard
// holding expected requester, data, error flag and ack cycle.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, wr0, wr1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err, busy, Mem_rd, Mem_wr;
  logic [31:0] rdata, Dir_Mem, Dato_Mem_in;
  logic [31:0] Dato_Mem_out = 32'd0;
  logic [31:0] bank [3] = '{32'h11111111, 32'h22222222, 32'h33333333};

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rd_pulses = 0;
  int   wr_pulses = 0;
  bit   acked;
  int   ack_id;

  mem_arbiter #(.BASE(32'h10000000), .NREG(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .Mem_rd(Mem_rd), .Mem_wr(Mem_wr), .Dir_Mem(Dir_Mem),
    .Dato_Mem_in(Dato_Mem_in), .Dato_Mem_out(Dato_Mem_out)
  );

  always #5 clk = ~clk;

  // Register bank: read data and writes take effect on the edge that sees the strobe low
  always @(posedge clk) begin
    logic [31:0] off;
    off = (Dir_Mem - 32'h10000000) >> 2;
    if (off < 32'd3) begin
      if (Mem_rd === 1'b0) Dato_Mem_out <= bank[off[1:0]];
      if (Mem_wr === 1'b0) bank[off[1:0]] <= Dato_Mem_in;
    end
  end

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    acked = 1'b0;
    checks++;
    assert ((Mem_rd | Mem_wr) === 1'b1) else begin
      failures++;
      $error("FAIL strobes_both_low cyc=%0d observed rd=%b wr=%b expected at least one high", cyc, Mem_rd, Mem_wr);
    end
    if (Mem_rd === 1'b0) rd_pulses++;
    if (Mem_wr === 1'b0) wr_pulses++;
    if (ack0 === 1'b1 || ack1 === 1'b1) begin
      checks++;
      assert ((ack0 & ack1) === 1'b0) else begin
        failures++;
        $error("FAIL both_acks cyc=%0d observed ack0=%b ack1=%b expected one", cyc, ack0, ack1);
      end
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_ack cyc=%0d observed ack0=%b ack1=%b expected none", cyc, ack0, ack1);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        acked  = 1'b1;
        ack_id = (ack1 === 1'b1) ? 1 : 0;
        checks++;
        assert (ack_id === e.id) else begin
          failures++;
          $error("FAIL ack_id cyc=%0d observed %0d expected %0d", cyc, ack_id, e.id);
        end
        checks++;
        assert (rdata === e.rdata) else begin
          failures++;
          $error("FAIL ack_rdata cyc=%0d observed %h expected %h", cyc, rdata, e.rdata);
        end
        checks++;
        assert (err === e.err) else begin
          failures++;
          $error("FAIL ack_err cyc=%0d observed %b expected %b", cyc, err, e.err);
        end
        checks++;
        assert (cyc === e.cyc) else begin
          failures++;
          $error("FAIL ack_cycle observed %0d expected %0d", cyc, e.cyc);
        end
      end
    end else begin
      checks++;
      assert ({rdata, err} === 33'd0) else begin
        failures++;
        $error("FAIL idle_resp cyc=%0d observed rdata=%h err=%b expected 0/0", cyc, rdata, err);
      end
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] rd, input logic er, input int at);
    exp_t e;
    e.id = id; e.rdata = rd; e.err = er; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; ack due 3 cycles after acceptance
  task automatic do_txn(input int id, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic ee);
    bit done;
    if (id == 0) begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d; end
    else         begin req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; end
    push_exp(id, er, ee, cyc + 3);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (acked && ack_id == id) done = 1'b1;
    end
    check32("txn_done", {31'd0, done}, 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  initial begin
    int n, rd0, wr0c;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (3) tick();
    check32("rst_acks", {30'd0, ack0, ack1}, 32'd0);
    check32("rst_busy_err", {30'd0, busy, err}, 32'd0);
    check32("rst_rdata", rdata, 32'd0);
    check32("rst_strobes", {30'd0, Mem_rd, Mem_wr}, 32'd3);
    check32("rst_dir", Dir_Mem, 32'd0);
    check32("rst_dato", Dato_Mem_in, 32'd0);

    // Both requesters contend from reset: 0,1,0,1
    rst_n = 1'b1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h10000000;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h10000008;
    n = cyc; rd0 = rd_pulses;
    push_exp(0, 32'h11111111, 1'b0, n + 3);
    push_exp(1, 32'h33333333, 1'b0, n + 7);
    push_exp(0, 32'h11111111, 1'b0, n + 11);
    push_exp(1, 32'h33333333, 1'b0, n + 15);
    repeat (15) tick();
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check32("rr_all_acked", sb.size(), 32'd0);
    check32("rr_rd_pulses", rd_pulses - rd0, 32'd4);

    // Write then read back through requester 0
    rd0 = rd_pulses; wr0c = wr_pulses;
    do_txn(0, 1'b1, 32'h10000004, 32'hA5A5A5A5, 32'd0, 1'b0);
    check32("wr_pulse", wr_pulses - wr0c, 32'd1);
    check32("wr_no_rd", rd_pulses - rd0, 32'd0);
    rd0 = rd_pulses; wr0c = wr_pulses;
    do_txn(0, 1'b0, 32'h10000004, 32'd0, 32'hA5A5A5A5, 1'b0);
    check32("rd_pulse", rd_pulses - rd0, 32'd1);
    check32("rd_no_wr", wr_pulses - wr0c, 32'd0);

    // Unmapped: past the last register, and misaligned
    rd0 = rd_pulses; wr0c = wr_pulses;
    do_txn(1, 1'b0, 32'h1000000C, 32'd0, 32'd0, 1'b1);
    do_txn(1, 1'b0, 32'h10000002, 32'd0, 32'd0, 1'b1);
    check32("unmap_no_strobe", (rd_pulses - rd0) + (wr_pulses - wr0c), 32'd0);

    // Inputs changed after acceptance must not affect the transaction
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h10000004;
    push_exp(0, 32'hA5A5A5A5, 1'b0, cyc + 3);
    tick();
    check32("hold_dir_issue", Dir_Mem, 32'h10000004);
    check32("hold_rd_low", {31'd0, Mem_rd}, 32'd0);
    addr0 = 32'h10000008; wr0 = 1'b1; wdata0 = 32'hFFFFFFFF;
    tick();
    check32("hold_dir_capt", Dir_Mem, 32'h10000004);
    tick();
    req0 = 1'b0;
    tick();
    check32("hold_acked", sb.size(), 32'd0);

    // Reset while a write is in ISSUE
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h10000000; wdata0 = 32'hDEADBEEF;
    tick();
    check32("abort_wr_low", {31'd0, Mem_wr}, 32'd0);
    rst_n = 1'b0; req0 = 1'b0;
    tick();
    check32("abort_busy", {31'd0, busy}, 32'd0);
    check32("abort_strobes", {30'd0, Mem_rd, Mem_wr}, 32'd3);
    rst_n = 1'b1;
    repeat (4) tick();
    // Last grant before reset was requester 0; reset must restore requester 0 priority
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h10000004;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h10000008;
    push_exp(0, 32'hA5A5A5A5, 1'b0, cyc + 3);
    push_exp(1, 32'h33333333, 1'b0, cyc + 7);
    repeat (3) tick();
    req0 = 1'b0;
    repeat (4) tick();
    req1 = 1'b0;
    repeat (2) tick();
    check32("final_sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed no finish expected finish before 100us");
    $fatal(1, "timeout");
  end

endmodule
